// File: rtl/sat_arith_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sat_arith_pkg
//  Description : Shared saturating-arithmetic definitions: signed limits for
//                the default datapath width, accumulator FSM state type and a
//                reference saturating add function.
//  Revision    : 1.0 - initial release
// ============================================================================
package sat_arith_pkg;

  // Default datapath width; the limits below are derived from it.
  localparam int SAT_W = 4;

  // Largest positive and most negative two's-complement values at SAT_W.
  localparam logic [SAT_W-1:0] MAX_POS = {1'b0, {(SAT_W-1){1'b1}}};
  localparam logic [SAT_W-1:0] MIN_NEG = {1'b1, {(SAT_W-1){1'b0}}};

  // ACC collects samples, HOLD presents the finished frame sum.
  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Saturating signed add at SAT_W; ovf flags a clamped result.
  function automatic logic [SAT_W-1:0] sat_add(
    input  logic [SAT_W-1:0] a,
    input  logic [SAT_W-1:0] b,
    output logic             ovf
  );
    logic [SAT_W-1:0] sum;
    sum = a + b;
    ovf = (a[SAT_W-1] == b[SAT_W-1]) && (sum[SAT_W-1] != a[SAT_W-1]);
    if (ovf) begin
      sat_add = a[SAT_W-1] ? MIN_NEG : MAX_POS;
    end else begin
      sat_add = sum;
    end
  endfunction

endpackage : sat_arith_pkg
`default_nettype wire

// File: rtl/signed_sat_add_w.sv
`default_nettype none
// ============================================================================
//  Module      : signed_sat_add_w
//  Description : Combinational W-bit signed saturating adder. Clamps to the
//                positive/negative limit when equal-sign operands produce a
//                result of the opposite sign, and reports that as ovf.
//  Revision    : 1.0 - initial release
// ============================================================================
module signed_sat_add_w #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y,
  output logic         ovf
);

  localparam logic [W-1:0] C_MAX_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] C_MIN_NEG = {1'b1, {(W-1){1'b0}}};

  logic [W-1:0] w_sum;
  logic         w_ovf;

  // Wrapping sum, overflow detection from operand/result signs, then clamp.
  always_comb begin
    w_sum = a + b;
    w_ovf = (a[W-1] == b[W-1]) && (w_sum[W-1] != a[W-1]);
    y     = w_sum;
    if (w_ovf) begin
      y = a[W-1] ? C_MIN_NEG : C_MAX_POS;
    end
  end

  assign ovf = w_ovf;

endmodule : signed_sat_add_w
`default_nettype wire

// File: rtl/sat_accum_frame.sv
`default_nettype none
// ============================================================================
//  Module      : sat_accum_frame
//  Description : Streaming signed frame accumulator with per-step saturation.
//                Collects up to LEN samples (or fewer, ending on in_last),
//                then holds the saturated sum, sticky saturation flag and
//                sample count on a valid/ready output until accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_accum_frame
  import sat_arith_pkg::*;
#(
  parameter int W   = 4,
  parameter int LEN = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [W-1:0]               in_data,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [W-1:0]               out_data,
  output logic                       out_sat,
  output logic [$clog2(LEN+1)-1:0]   out_count
);

  localparam int CW = $clog2(LEN + 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [W-1:0]    r_acc;
  logic [CW-1:0]   r_count;
  logic            r_sat;

  logic [W-1:0]    w_sum;
  logic            w_ovf;
  logic            w_take;
  logic            w_frame_end;
  logic            w_release;

  // The single adder in the accumulate loop: running total plus new sample.
  signed_sat_add_w #(
    .W (W)
  ) u_add (
    .a   (r_acc),
    .b   (in_data),
    .y   (w_sum),
    .ovf (w_ovf)
  );

  assign in_ready    = (r_state == ACC);
  assign out_valid   = (r_state == HOLD);
  assign w_take      = in_valid && in_ready;
  // Last slot of the frame is reached when this transfer makes LEN samples.
  assign w_frame_end = w_take && (in_last || (r_count == CW'(LEN - 1)));
  assign w_release   = (r_state == HOLD) && out_ready;

  assign out_data  = r_acc;
  assign out_sat   = r_sat;
  assign out_count = r_count;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ACC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: close the frame on its final sample, reopen on handshake.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ACC:     if (w_frame_end) w_state_nxt = HOLD;
      HOLD:    if (out_ready)   w_state_nxt = ACC;
      default: w_state_nxt = ACC;
    endcase
  end

  // Accumulator, sample counter and sticky saturation flag; the result
  // registers double as the held output, so they only clear on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_count <= '0;
      r_sat   <= 1'b0;
    end else if (w_take) begin
      r_acc   <= w_sum;
      r_count <= r_count + CW'(1);
      r_sat   <= r_sat | w_ovf;
    end else if (w_release) begin
      r_acc   <= '0;
      r_count <= '0;
      r_sat   <= 1'b0;
    end
  end

endmodule : sat_accum_frame
`default_nettype wire

// File: doc/sat_accum_frame.md
Name: sat_accum_frame

Overview:
Streaming signed accumulator that sums a frame of samples with per-step saturation. Sits directly downstream of the combinational signed saturating adder stage and reuses that arithmetic in a registered loop. Accepts samples over a valid/ready input, then emits one saturated frame sum over a valid/ready output. Used to build running totals for the arithmetic datapath exercises without wrap-around artefacts.

Parameters:
W, 4, sample and accumulator width in bits, two's complement
LEN, 4, maximum samples per frame (>=1); a frame also ends early on in_last

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input sample present
in_ready  output  1  block accepts a sample this cycle
in_data  input  W  signed sample
in_last  input  1  sample is the last of its frame (qualified by in_valid)
out_valid  output  1  frame result present
out_ready  input  1  downstream accepts the result
out_data  output  W  signed saturated frame sum
out_sat  output  1  saturation occurred at any step of this frame (sticky)
out_count  output  $clog2(LEN+1)  number of samples in this frame

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rst_n); the polarity and synchronicity are fixed. Asserting rst_n low clears all state immediately.
- Reset values: state=ACC, acc=0, count=0, sat=0, out_valid=0, in_ready=1, out_data=0, out_sat=0, out_count=0.
- States: ACC (collecting samples) and HOLD (presenting the result).
- ACC state:
  - in_ready=1 and out_valid=0.
  - A sample transfers when in_valid && in_ready.
  - On transfer: acc <= sat_add(acc, in_data); count <= count+1; sat <= sat | overflow.
  - If the transfer is the LEN-th sample or in_last=1, go to HOLD at the same edge. The result registers take the post-add values.
- HOLD state:
  - in_ready=0 and out_valid=1.
  - out_data, out_sat and out_count are stable until the handshake.
  - On out_ready=1: clear acc, count and sat, and return to ACC. The next sample can be accepted the following cycle, giving 1 bubble cycle per frame.
- Latency: out_valid rises the cycle after the final sample transfer.
- Saturating add, evaluated per step:
  - Operands with equal signs whose W-bit result sign differs are an overflow.
  - Positive overflow gives 2^(W-1)-1 (4'b0111 at W=4). Negative overflow gives -2^(W-1) (4'b1000).
  - Mixed-sign operands never overflow.
  - Saturation applies per step, not to the final true sum: 7+1-1 yields 6, not 7.
- in_data is ignored when in_valid=0. in_last is ignored without a transfer.
- out_ready asserted while in ACC has no effect.
- LEN=1: every transfer goes directly to HOLD.
- Reset asserted mid-frame or mid-HOLD discards the partial or pending result; no output is produced for it.

Decomposition:
- Package sat_arith_pkg holds:
  - localparam-derived limits MAX_POS/MIN_NEG as functions of W;
  - typedef enum logic {ACC, HOLD} state_t;
  - function sat_add(a, b, output ovf), combinational.
- One sub-module, signed_sat_add_w: combinational W-parameterised saturating adder with an ovf output, instantiated once in the accumulate loop.
- The top holds the FSM, counter and registers.

Test Plan:
- W=4, LEN=4, in 1,2,3,-4 back-to-back with out_ready=1 -> out_data=2, out_sat=0, out_count=4, out_valid one cycle after the 4th transfer.
- In 7,1,-1,0 -> intermediate 7 (saturated), final out_data=6, out_sat=1, out_count=4.
- In -8,-1,1,0 -> out_data=-7 (4'b1001), out_sat=1.
- In 3 then 2 with in_last=1 -> out_data=5, out_sat=0, out_count=2. The next frame starts clean (acc=0).
- Backpressure: hold out_ready=0 for 3 cycles in HOLD with in_valid=1 -> in_ready=0, no samples consumed, outputs stable. Then out_ready=1 -> return to ACC, next sample accepted one cycle later.
- Pull rst_n low asynchronously after 2 samples (and separately during HOLD) -> out_valid=0, in_ready=1 immediately. After release, a fresh frame 1,1,1,1 gives out_data=4, out_count=4.
